fetch_line_responder: RTL and testbench

- Instruction-side responder that serves the fetch window's paired line requests: every cycle it takes a low and a high 16-byte-aligned line address and returns both 128-bit lines one cycle later.
- Lines are held in a small fully-associative line buffer.
- Misses are filled from a 32-bit backing memory port, one beat at a time, under a request/valid handshake.
- Per-line valid flags tell the front end which returned lines are usable.

---
 rtl/fetch_line_responder.sv | 193 +++++++++++++++++++
 tb/tb_fetch_line_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_responder.sv
// Instruction fetch line responder.
// Serves a low and a high 16-byte line request every cycle from a small
// fully-associative line buffer. Registered results appear one edge after
// the request. Missing lines are filled one 32-bit beat at a time from the
// backing memory port; only one beat is ever outstanding.
module fetch_line_responder #(
    parameter int LINE_ENTRIES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  lowFetchAddress,
    input  logic [31:0]  highFetchAddress,
    input  logic         flush,
    output logic [127:0] lowFetchData,
    output logic [127:0] highFetchData,
    output logic         lowValid,
    output logic         highValid,
    output logic         memRead,
    output logic [31:0]  memAddress,
    input  logic         memAccept,
    input  logic         memDataValid,
    input  logic [31:0]  memData
);

    localparam int IDX_W = $clog2(LINE_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        INSTALL,
        DRAIN
    } fillState_e;

    fillState_e state;
    fillState_e stateNext;

    logic [LINE_ENTRIES-1:0] entryValid;
    logic [27:0]             entryTag  [LINE_ENTRIES];
    logic [127:0]            entryData [LINE_ENTRIES];
    logic [IDX_W-1:0]        victim;

    logic [27:0]  fillTag;
    logic [1:0]   beat;
    logic [127:0] fillData;

    logic             lowHit;
    logic             highHit;
    logic             fillHit;
    logic [IDX_W-1:0] lowIdx;
    logic [IDX_W-1:0] highIdx;
    logic [27:0]      missTag;

    // The offset bits inside a line never take part in a lookup.
    logic unusedOffsetBits;
    assign unusedOffsetBits = ^{lowFetchAddress[3:0], highFetchAddress[3:0]};

    // Low misses are serviced first; if low hits, the high line is the one missing.
    assign missTag = lowHit ? highFetchAddress[31:4] : lowFetchAddress[31:4];

    // Associative tag compare of both requests and of the line being filled.
    always_comb begin
        lowHit  = 1'b0;
        highHit = 1'b0;
        fillHit = 1'b0;
        lowIdx  = '0;
        highIdx = '0;
        for (int i = 0; i < LINE_ENTRIES; i++) begin
            if (entryValid[i] && (entryTag[i] == lowFetchAddress[31:4])) begin
                lowHit = 1'b1;
                lowIdx = IDX_W'(i);
            end
            if (entryValid[i] && (entryTag[i] == highFetchAddress[31:4])) begin
                highHit = 1'b1;
                highIdx = IDX_W'(i);
            end
            if (entryValid[i] && (entryTag[i] == fillTag)) begin
                fillHit = 1'b1;
            end
        end
    end

    // Fill sequencer next state and memory request outputs.
    always_comb begin
        stateNext  = state;
        memRead    = 1'b0;
        memAddress = 32'h0;
        case (state)
            IDLE: begin
                if (!flush && (!lowHit || !highHit)) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                memRead    = 1'b1;
                memAddress = {fillTag, beat, 2'b00};
                if (memAccept) begin
                    stateNext = flush ? DRAIN : WAIT;
                end else if (flush) begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (memDataValid) begin
                    if (flush) begin
                        stateNext = IDLE;
                    end else if (beat == 2'd3) begin
                        stateNext = INSTALL;
                    end else begin
                        stateNext = ISSUE;
                    end
                end else if (flush) begin
                    stateNext = DRAIN;
                end
            end
            INSTALL: begin
                stateNext = IDLE;
            end
            DRAIN: begin
                if (memDataValid) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Capture the line being filled and assemble its beats in word order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fillTag  <= 28'h0;
            beat     <= 2'd0;
            fillData <= 128'h0;
        end else begin
            if ((state == IDLE) && (stateNext == ISSUE)) begin
                fillTag <= missTag;
                beat    <= 2'd0;
            end
            if ((state == WAIT) && memDataValid) begin
                fillData[{beat, 5'b00000} +: 32] <= memData;
                beat                             <= beat + 2'd1;
            end
        end
    end

    // Entry valid bits and round-robin victim; a flush wins over an install.
    always_ff @(posedge clock) begin
        if (!reset) begin
            entryValid <= '0;
            victim     <= '0;
        end else if (flush) begin
            entryValid <= '0;
        end else if ((state == INSTALL) && !fillHit) begin
            entryValid[victim] <= 1'b1;
            victim             <= victim + IDX_W'(1);
        end
    end

    // Tag and data payload only matter while the entry is valid, so no reset.
    always_ff @(posedge clock) begin
        if ((state == INSTALL) && !fillHit && !flush) begin
            entryTag[victim]  <= fillTag;
            entryData[victim] <= fillData;
        end
    end

    // Registered lookup results; a flush forces both lines unusable at once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lowFetchData  <= 128'h0;
            highFetchData <= 128'h0;
            lowValid      <= 1'b0;
            highValid     <= 1'b0;
        end else begin
            lowValid      <= lowHit && !flush;
            highValid     <= highHit && !flush;
            lowFetchData  <= (lowHit && !flush) ? entryData[lowIdx] : 128'h0;
            highFetchData <= (highHit && !flush) ? entryData[highIdx] : 128'h0;
        end
    end

endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder with a 2-cycle-latency memory model
// whose word at address A holds A ^ 32'hA5A5_0000.
module tb_fetch_line_responder;

    logic         clock;
    logic         reset;
    logic [31:0]  lowFetchAddress;
    logic [31:0]  highFetchAddress;
    logic         flush;
    logic [127:0] lowFetchData;
    logic [127:0] highFetchData;
    logic         lowValid;
    logic         highValid;
    logic         memRead;
    logic [31:0]  memAddress;
    logic         memAccept;
    logic         memDataValid;
    logic [31:0]  memData;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] readLog [$];
    logic [31:0] pendAddr;
    int          countdown;

    fetch_line_responder #(.LINE_ENTRIES(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .lowFetchAddress  (lowFetchAddress),
        .highFetchAddress (highFetchAddress),
        .flush            (flush),
        .lowFetchData     (lowFetchData),
        .highFetchData    (highFetchData),
        .lowValid         (lowValid),
        .highValid        (highValid),
        .memRead          (memRead),
        .memAddress       (memAddress),
        .memAccept        (memAccept),
        .memDataValid     (memDataValid),
        .memData          (memData)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: accepts at the edge where memRead && memAccept, returns data two edges later.
    initial begin
        memDataValid = 1'b0;
        memData      = 32'h0;
        pendAddr     = 32'h0;
        countdown    = 0;
        forever begin
            @(posedge clock);
            #2;
            memDataValid = 1'b0;
            if (countdown > 0) begin
                countdown = countdown - 1;
                if (countdown == 0) begin
                    memDataValid = 1'b1;
                    memData      = pendAddr ^ 32'hA5A5_0000;
                end
            end
            if (memRead && memAccept) begin
                readLog.push_back(memAddress);
                pendAddr  = memAddress;
                countdown = 2;
            end
        end
    end

    function automatic logic [127:0] lineOf(input logic [31:0] base);
        logic [127:0] line;
        for (int k = 0; k < 4; k++) begin
            line[32*k +: 32] = (base + 32'(4 * k)) ^ 32'hA5A5_0000;
        end
        return line;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance at least one edge, then until the requested valids are up or the budget runs out.
    task automatic waitValid(input int budget, input bit needHigh, output bit ok);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!((lowValid === 1'b1) && (!needHigh || (highValid === 1'b1))) && (cyc < budget));
        ok = (lowValid === 1'b1) && (!needHigh || (highValid === 1'b1));
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        flush            = 1'b0;
        memAccept        = 1'b1;
        lowFetchAddress  = 32'h0000_1000;
        highFetchAddress = 32'h0000_1010;
        tick();
        tick();
        compared++;
        if (lowValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_lowValid: got %b, expected 0", lowValid); end
        compared++;
        if (highValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_highValid: got %b, expected 0", highValid); end
        compared++;
        if (lowFetchData !== 128'h0) begin mismatched++; $display("[TB] FAIL reset_lowData: got %h, expected 0", lowFetchData); end
        compared++;
        if (highFetchData !== 128'h0) begin mismatched++; $display("[TB] FAIL reset_highData: got %h, expected 0", highFetchData); end
        compared++;
        if (memRead !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memRead: got %b, expected 0", memRead); end
        compared++;
        if (memAddress !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_memAddress: got %h, expected 0", memAddress); end
        readLog.delete();
        reset = 1'b1;
    endtask

    task automatic test_cold_miss();
        bit ok;
        logic [31:0] seen;
        waitValid(100, 1'b1, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL cold_timeout: lowValid=%b highValid=%b, expected both 1", lowValid, highValid); end
        compared++;
        if (lowFetchData[31:0] !== 32'hA5A5_1000) begin mismatched++; $display("[TB] FAIL cold_low_word0: got %h, expected a5a51000", lowFetchData[31:0]); end
        compared++;
        if (lowFetchData[127:96] !== 32'hA5A5_100C) begin mismatched++; $display("[TB] FAIL cold_low_word3: got %h, expected a5a5100c", lowFetchData[127:96]); end
        compared++;
        if (highFetchData[31:0] !== 32'hA5A5_1010) begin mismatched++; $display("[TB] FAIL cold_high_word0: got %h, expected a5a51010", highFetchData[31:0]); end
        compared++;
        if (highFetchData !== lineOf(32'h0000_1010)) begin mismatched++; $display("[TB] FAIL cold_high_line: got %h, expected %h", highFetchData, lineOf(32'h0000_1010)); end
        tick();
        tick();
        compared++;
        if (readLog.size() !== 8) begin mismatched++; $display("[TB] FAIL cold_beat_count: got %0d, expected 8", readLog.size()); end
        for (int i = 0; i < 8; i++) begin
            seen = (i < readLog.size()) ? readLog[i] : 32'hFFFF_FFFF;
            compared++;
            if (seen !== 32'h0000_1000 + 32'(4 * i)) begin
                mismatched++;
                $display("[TB] FAIL cold_beat_addr%0d: got %h, expected %h", i, seen, 32'h0000_1000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_same_line();
        bit ok;
        readLog.delete();
        lowFetchAddress  = 32'h0000_2000;
        highFetchAddress = 32'h0000_2000;
        waitValid(100, 1'b1, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL same_timeout: lowValid=%b highValid=%b, expected both 1", lowValid, highValid); end
        compared++;
        if (lowFetchData !== lineOf(32'h0000_2000)) begin mismatched++; $display("[TB] FAIL same_low_line: got %h, expected %h", lowFetchData, lineOf(32'h0000_2000)); end
        compared++;
        if (highFetchData !== lineOf(32'h0000_2000)) begin mismatched++; $display("[TB] FAIL same_high_line: got %h, expected %h", highFetchData, lineOf(32'h0000_2000)); end
        tick();
        tick();
        compared++;
        if (readLog.size() !== 4) begin mismatched++; $display("[TB] FAIL same_beat_count: got %0d, expected 4", readLog.size()); end
    endtask

    task automatic test_hit_latency();
        bit ok;
        lowFetchAddress  = 32'h0000_3000;
        highFetchAddress = 32'h0000_1000;
        tick();
        compared++;
        if (lowValid !== 1'b0) begin mismatched++; $display("[TB] FAIL hit_miss_edge: lowValid got %b, expected 0", lowValid); end
        compared++;
        if (highValid !== 1'b1) begin mismatched++; $display("[TB] FAIL hit_high_resident: highValid got %b, expected 1", highValid); end
        lowFetchAddress = 32'h0000_1000;
        tick();
        compared++;
        if (lowValid !== 1'b1) begin mismatched++; $display("[TB] FAIL hit_next_edge: lowValid got %b, expected 1", lowValid); end
        compared++;
        if (lowFetchData !== lineOf(32'h0000_1000)) begin mismatched++; $display("[TB] FAIL hit_data: got %h, expected %h", lowFetchData, lineOf(32'h0000_1000)); end
        lowFetchAddress = 32'h0000_3000;
        waitValid(60, 1'b0, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL hit_fill_completes: lowValid got %b, expected 1", lowValid); end
        compared++;
        if (lowFetchData !== lineOf(32'h0000_3000)) begin mismatched++; $display("[TB] FAIL hit_fill_data: got %h, expected %h", lowFetchData, lineOf(32'h0000_3000)); end
    endtask

    task automatic test_stall_and_flush();
        bit ok;
        logic [31:0] seen;
        readLog.delete();
        memAccept        = 1'b0;
        flush            = 1'b1;
        lowFetchAddress  = 32'h0000_1000;
        highFetchAddress = 32'h0000_1000;
        tick();
        compared++;
        if ((lowValid !== 1'b0) || (highValid !== 1'b0)) begin mismatched++; $display("[TB] FAIL flush_valids: got %b%b, expected 00", lowValid, highValid); end
        flush = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ((memRead !== 1'b1) || (memAddress !== 32'h0000_1000)) begin
                mismatched++;
                $display("[TB] FAIL stall_hold%0d: memRead=%b memAddress=%h, expected 1 00001000", i, memRead, memAddress);
            end
            tick();
        end
        memAccept = 1'b1;
        tick();
        compared++;
        if (memRead !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_memRead: got %b, expected 0", memRead); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++;
        if (memRead !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_memRead: got %b, expected 0", memRead); end
        tick();
        compared++;
        if ((lowValid !== 1'b0) || (highValid !== 1'b0) || (memRead !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL drain_done: valids=%b%b memRead=%b, expected 00 0", lowValid, highValid, memRead);
        end
        tick();
        compared++;
        if ((memRead !== 1'b1) || (memAddress !== 32'h0000_1000)) begin
            mismatched++;
            $display("[TB] FAIL refetch_beat0: memRead=%b memAddress=%h, expected 1 00001000", memRead, memAddress);
        end
        waitValid(60, 1'b1, ok);
        compared++;
        if (!ok || (lowFetchData !== lineOf(32'h0000_1000))) begin
            mismatched++;
            $display("[TB] FAIL refetch_line: valid=%b got %h, expected %h", lowValid, lowFetchData, lineOf(32'h0000_1000));
        end
        seen = (readLog.size() > 1) ? readLog[1] : 32'hFFFF_FFFF;
        compared++;
        if ((readLog.size() !== 5) || (seen !== 32'h0000_1000)) begin
            mismatched++;
            $display("[TB] FAIL refetch_log: count=%0d second=%h, expected 5 00001000", readLog.size(), seen);
        end
    endtask

    task automatic test_eviction();
        bit ok;
        logic [31:0] addrs [5];
        addrs = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lowFetchAddress  = addrs[i];
            highFetchAddress = addrs[i];
            waitValid(80, 1'b0, ok);
            compared++;
            if (!ok || (lowFetchData !== lineOf(addrs[i]))) begin
                mismatched++;
                $display("[TB] FAIL evict_fill%0d: valid=%b got %h, expected %h", i, lowValid, lowFetchData, lineOf(addrs[i]));
            end
        end
        lowFetchAddress  = 32'h00;
        highFetchAddress = 32'h10;
        tick();
        compared++;
        if (lowValid !== 1'b0) begin mismatched++; $display("[TB] FAIL evict_oldest_gone: lowValid got %b, expected 0", lowValid); end
        compared++;
        if ((highValid !== 1'b1) || (highFetchData !== lineOf(32'h10))) begin
            mismatched++;
            $display("[TB] FAIL evict_keep10: valid=%b got %h, expected %h", highValid, highFetchData, lineOf(32'h10));
        end
        lowFetchAddress  = 32'h20;
        highFetchAddress = 32'h30;
        tick();
        compared++;
        if ((lowValid !== 1'b1) || (highValid !== 1'b1)) begin mismatched++; $display("[TB] FAIL evict_keep20_30: valids=%b%b, expected 11", lowValid, highValid); end
        lowFetchAddress  = 32'h40;
        highFetchAddress = 32'h40;
        tick();
        compared++;
        if ((lowValid !== 1'b1) || (lowFetchData !== lineOf(32'h40))) begin
            mismatched++;
            $display("[TB] FAIL evict_keep40: valid=%b got %h, expected %h", lowValid, lowFetchData, lineOf(32'h40));
        end
        lowFetchAddress  = 32'h00;
        highFetchAddress = 32'h00;
        waitValid(80, 1'b0, ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL evict_refill0: lowValid got %b, expected 1", lowValid); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int cyc;
        lowFetchAddress  = 32'h0000_5000;
        highFetchAddress = 32'h0000_5000;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while ((memRead !== 1'b1) && (cyc < 20));
        compared++;
        if (memRead !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_issue_timeout: memRead got %b, expected 1", memRead); end
        tick();
        reset = 1'b0;
        tick();
        compared++;
        if ((lowValid !== 1'b0) || (highValid !== 1'b0) || (lowFetchData !== 128'h0) || (highFetchData !== 128'h0)) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_outputs: valids=%b%b low=%h high=%h, expected all 0", lowValid, highValid, lowFetchData, highFetchData);
        end
        compared++;
        if ((memRead !== 1'b0) || (memAddress !== 32'h0)) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_mem: memRead=%b memAddress=%h, expected 0 0", memRead, memAddress);
        end
        reset = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        compared++;
        if (memRead !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_late_idle: memRead got %b, expected 0", memRead); end
        tick();
        compared++;
        if ((memRead !== 1'b1) || (memAddress !== 32'h0000_5000)) begin
            mismatched++;
            $display("[TB] FAIL rst_restart_beat0: memRead=%b memAddress=%h, expected 1 00005000", memRead, memAddress);
        end
        waitValid(60, 1'b0, ok);
        compared++;
        if (!ok || (lowFetchData !== lineOf(32'h0000_5000))) begin
            mismatched++;
            $display("[TB] FAIL rst_refill_line: valid=%b got %h, expected %h", lowValid, lowFetchData, lineOf(32'h0000_5000));
        end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting fetch_line_responder bench");
        test_reset();
        test_cold_miss();
        test_same_line();
        test_hit_latency();
        test_stall_and_flush();
        test_eviction();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
